nic_sram_slave: RTL and testbench
=================================

// Module: nic_sram_slave
// PURPOSE
//  Slave-side responder for the nic select/ack/rdata interconnect: one instance sits on one nic slave port.
//  Wraps a word-addressed, byte-writable SRAM, accepts one request at a time, and inserts programmable wait states.
//  Returns o_ack and o_rdata aligned to the nic's registered select, one cycle after request with 0 wait states.
// PARAMETERS
//  DATA_WIDTH   32    data bus width, multiple of 8
//  ADDR_WIDTH   10    word address width
//  DEPTH        1024  number of words implemented, 1..2**ADDR_WIDTH
//  WAIT_STATES  0     extra cycles before ack, 0..15
// PORTS
//  i_clk      in   1             clock, all logic on posedge
//  i_reset    in   1             synchronous, active-high reset
//  i_sel      in   1             slave select from nic o_slave_sel[n]
//  i_addr     in   ADDR_WIDTH    word address, valid while i_sel
//  i_we       in   1             1=write, 0=read
//  i_wstrb    in   DATA_WIDTH/8  byte write enables, bit k -> bits 8k+7:8k
//  i_wdata    in   DATA_WIDTH    write data
//  o_rdata    out  DATA_WIDTH    read data, valid only with o_ack, else 0
//  o_ack      out  1             one-cycle response pulse
// BEHAVIOUR
//  - Single clock i_clk; i_reset synchronous active-high; all state updates on posedge i_clk.
//  - Reset: state IDLE, wait counter 0, o_ack 0, o_rdata 0, o_err 0 (if present). SRAM contents not cleared.
//  - FSM: IDLE, WAIT, RESP.
//  - IDLE: i_sel=1 accepts the request. Latch i_addr, i_we, i_wstrb and i_wdata.
//    - WAIT_STATES=0: perform the SRAM access on the same edge and go to RESP.
//    - Otherwise: load counter with WAIT_STATES-1 and go to WAIT.
//  - WAIT: counter decrements each cycle. At counter 0, perform the SRAM access from the latched request and go to RESP.
//  - RESP: o_ack=1 for exactly one cycle, then IDLE. i_sel is ignored in RESP, because the master still holds the old request that cycle.
//  - Latency: i_sel first high in cycle N gives o_ack in cycle N+1+WAIT_STATES.
//  - Master holds i_sel, i_addr, i_we, i_wstrb and i_wdata stable through cycle N+WAIT_STATES. Later changes have no effect on the request.
//  - Back-to-back: a new i_sel in the cycle after o_ack is accepted. Max throughput is 1 request per 2+WAIT_STATES cycles.
//  - Read: o_rdata = mem[addr] during the o_ack cycle, registered. o_rdata=0 in every other cycle, so it ORs cleanly on the nic bus.
//  - Write: mem[addr] byte k updated iff i_wstrb[k]. i_wstrb=0 is a no-op that still acks. o_rdata=0 on write ack.
//  - Read-after-write to the same word in back-to-back requests returns the new data.
//  - Out-of-range address (addr >= DEPTH): write suppressed, read returns 0, ack issued normally.
//  - i_sel dropped during WAIT: the request still completes and acks; it is not cancelled.
//  - i_reset during WAIT: the request is aborted, with no SRAM write and no ack.
//  - i_reset during the RESP cycle: o_ack=0 from the next cycle. A write already performed stays in the SRAM.
// CONFIGURATION
//  - Macro NIC_SRAM_ERR_EN adds port: o_err  out  1  error flag, asserted only together with o_ack.
//  - Defined: o_err=1 in the ack cycle of an out-of-range access; o_rdata=0 and the write is still suppressed. o_err resets to 0.
//  - Not defined: o_err port absent; out-of-range handling otherwise identical.
// STRUCTURE
//  - Package nic_pkg: typedef enum logic[1:0] {NIC_IDLE, NIC_WAIT, NIC_RESP} nic_slv_state_t;
//    localparam NIC_WAIT_CNT_W = 4; function nic_bytes(dw) = dw/8.
//  - Sub-module nic_sram_array: DEPTH x DATA_WIDTH synchronous SRAM with byte write enables and registered read.
//    It is the only memory storage. FSM, counter and range check live in nic_sram_slave.
// TESTING
//  1. Reset, WAIT_STATES=0. Write 0xDEADBEEF to addr 5 with wstrb=4'hF, sel in cycle N -> o_ack=1 in N+1, o_rdata=0.
//     Then read addr 5 -> o_rdata=0xDEADBEEF with ack.
//  2. Partial write: wstrb=4'b0010 with wdata=0x0000AA00 to addr 5 -> a later read returns 0xDEADAAEF.
//     A write with wstrb=0 leaves the word unchanged and still acks.
//  3. WAIT_STATES=3: sel held from cycle N -> o_ack only in N+4, exactly one cycle wide.
//     o_rdata=0 in N+1..N+3 and in N+5.
//  4. Back-to-back: write addr 7 = 0x1234, new sel the cycle after its ack reading addr 7 -> 0x1234.
//     sel left high in the RESP cycle does not start an extra request.
//  5. DEPTH=1000: write 0x55 to addr 1000, then read addr 1000 -> rdata 0, and addr 0 is unchanged.
//     With NIC_SRAM_ERR_EN, o_err=1 in both ack cycles.
//  6. WAIT_STATES=3: i_reset pulsed during WAIT of a write to addr 2 -> no ack, addr 2 keeps its old value.
//     The next request after reset completes normally.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared types and helpers for the nic slave-side responders.
package nic_pkg;
  typedef enum logic [1:0] {NIC_IDLE, NIC_WAIT, NIC_RESP} nic_slv_state_t;

  localparam int NIC_WAIT_CNT_W = 4;

  function automatic int nic_bytes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/nic_sram_array.sv
// DEPTH x DATA_WIDTH synchronous SRAM, byte write enables, registered read.
// Stored as one byte-wide memory per byte lane.
module nic_sram_array import nic_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                             i_clk,
  input  logic                             i_en,
  input  logic                             i_we,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic [nic_bytes(DATA_WIDTH)-1:0] i_wstrb,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  output logic [DATA_WIDTH-1:0]            o_rdata
);
  localparam int NB = nic_bytes(DATA_WIDTH);

  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge i_clk) begin
      if (i_en && i_we && i_wstrb[k]) mem[i_addr] <= i_wdata[8*k +: 8];
      if (i_en && !i_we)              rd_q        <= mem[i_addr];
    end

    assign o_rdata[8*k +: 8] = rd_q;
  end
endmodule

// File: rtl/nic_sram_slave.sv
// nic slave port responder: SRAM behind a select/ack handshake with WAIT_STATES latency.
// Define NIC_SRAM_ERR_EN to add o_err, flagging out-of-range accesses in the ack cycle.
module nic_sram_slave import nic_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_sel,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic                             i_we,
  input  logic [nic_bytes(DATA_WIDTH)-1:0] i_wstrb,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic                             o_ack
`ifdef NIC_SRAM_ERR_EN
  ,
  output logic                             o_err
`endif
);
  localparam int NB = nic_bytes(DATA_WIDTH);

  nic_slv_state_t            state_q, state_d;
  logic [NIC_WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                      load, acc;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [NB-1:0]         wstrb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_q, oor_q;

  // With zero wait states the access fires on the accept edge, so it uses the live bus.
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_we;
  logic [NB-1:0]         a_wstrb;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  in_rng;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign a_addr  = (state_q == NIC_IDLE) ? i_addr  : addr_q;
  assign a_we    = (state_q == NIC_IDLE) ? i_we    : we_q;
  assign a_wstrb = (state_q == NIC_IDLE) ? i_wstrb : wstrb_q;
  assign a_wdata = (state_q == NIC_IDLE) ? i_wdata : wdata_q;
  assign in_rng  = 32'(a_addr) < 32'(DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    acc     = 1'b0;
    case (state_q)
      NIC_IDLE: if (i_sel) begin
        load = 1'b1;
        if (WAIT_STATES == 0) begin
          acc     = 1'b1;
          state_d = NIC_RESP;
        end else begin
          cnt_d   = NIC_WAIT_CNT_W'(WAIT_STATES - 1);
          state_d = NIC_WAIT;
        end
      end
      NIC_WAIT: if (cnt_q == '0) begin
        acc     = 1'b1;
        state_d = NIC_RESP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = NIC_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= NIC_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc) begin
        rd_q  <= !a_we && in_rng;
        oor_q <= !in_rng;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (load) begin
      addr_q  <= i_addr;
      we_q    <= i_we;
      wstrb_q <= i_wstrb;
      wdata_q <= i_wdata;
    end
  end

  nic_sram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .i_clk  (i_clk),
    .i_en   (acc && in_rng && !i_reset),
    .i_we   (a_we),
    .i_addr (a_addr),
    .i_wstrb(a_wstrb),
    .i_wdata(a_wdata),
    .o_rdata(arr_rdata)
  );

  assign o_ack   = (state_q == NIC_RESP);
  assign o_rdata = (o_ack && rd_q) ? arr_rdata : '0;
`ifdef NIC_SRAM_ERR_EN
  assign o_err   = o_ack && oor_q;
`endif
endmodule

// File: tb/tb_nic_sram_slave.sv
// Scoreboard bench: dut0 has WAIT_STATES=0, dut1 WAIT_STATES=3, both DEPTH=1000.
module tb_nic_sram_slave;
  localparam int DEPTH = 1000;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst   [2];
  logic        sel   [2];
  logic        we_s  [2];
  logic [9:0]  addr_s[2];
  logic [3:0]  st_s  [2];
  logic [31:0] wd_s  [2];
  logic [31:0] rd_o  [2];
  logic        ack_o [2];
  logic        err_o [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t        q0[$], q1[$];
  logic [31:0] mem_m [2][1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nic_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_sel(sel[0]), .i_addr(addr_s[0]), .i_we(we_s[0]),
    .i_wstrb(st_s[0]), .i_wdata(wd_s[0]), .o_rdata(rd_o[0]), .o_ack(ack_o[0])
`ifdef NIC_SRAM_ERR_EN
    , .o_err(err_o[0])
`endif
  );

  nic_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_sel(sel[1]), .i_addr(addr_s[1]), .i_we(we_s[1]),
    .i_wstrb(st_s[1]), .i_wdata(wd_s[1]), .o_rdata(rd_o[1]), .o_ack(ack_o[1])
`ifdef NIC_SRAM_ERR_EN
    , .o_err(err_o[1])
`endif
  );

`ifndef NIC_SRAM_ERR_EN
  assign err_o[0] = 1'b0;
  assign err_o[1] = 1'b0;
`endif

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic ack, input logic [31:0] rd, input logic er);
    exp_t e;
    bit   empty;
    if (ack !== 1'b1) begin
      chk("rdata_idle", d, rd, 32'h0);
      return;
    end
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack dut%0d cycle %0d: got ack expected none", d, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk("ack_cycle", d, 32'(cyc), 32'(e.cyc));
    chk("rdata", d, rd, e.rd);
`ifdef NIC_SRAM_ERR_EN
    chk("err", d, {31'b0, er}, {31'b0, e.err});
`else
    if (er !== 1'b0) $display("unexpected err value dut%0d", d);
`endif
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d, ack_o[d], rd_o[d], err_o[d]);
  end

  task automatic scramble(input int d);
    we_s[d]   = 1'($urandom);
    addr_s[d] = 10'($urandom);
    st_s[d]   = 4'($urandom);
    wd_s[d]   = $urandom;
  endtask

  // One request: sel rises in cycle N, held through N+ws unless dropped,
  // and resp_sel decides whether sel stays high during the ack cycle.
  task automatic req(input int d, input logic we, input logic [9:0] a, input logic [3:0] st,
                     input logic [31:0] wd, input bit drop, input bit resp_sel);
    int   ws;
    bit   oor;
    exp_t e;
    ws = (d == 0) ? 0 : 3;
    @(posedge clk); #1;
    sel[d] = 1'b1; we_s[d] = we; addr_s[d] = a; st_s[d] = st; wd_s[d] = wd;
    oor   = int'(a) >= DEPTH;
    e.cyc = cyc + 1 + ws;
    e.err = oor;
    e.rd  = (!we && !oor) ? mem_m[d][a] : 32'h0;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    if (we && !oor)
      for (int k = 0; k < 4; k++)
        if (st[k]) mem_m[d][a][8*k +: 8] = wd[8*k +: 8];
    for (int i = 0; i < ws; i++) begin
      @(posedge clk); #1;
      if (drop) begin
        sel[d] = 1'b0;
        scramble(d);
      end
    end
    @(posedge clk); #1;
    sel[d] = resp_sel;
    scramble(d);
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sel[d] = 1'b0;
    end
  endtask

  // Write to dut1 aborted by a reset pulse in its first WAIT cycle.
  task automatic abort_wr(input logic [9:0] a);
    @(posedge clk); #1;
    sel[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = a; st_s[1] = 4'hF; wd_s[1] = $urandom;
    @(posedge clk); #1;
    rst[1] = 1'b1; sel[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
  endtask

  initial begin
    logic [9:0] ra;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; sel[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = '0; st_s[d] = '0; wd_s[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", d, {31'b0, ack_o[d]}, 32'h0);
      chk("reset_rdata", d, rd_o[d], 32'h0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) req(d, 1'b1, 10'(a), 4'hF, $urandom, 1'b0, 1'b0);
    idle(0, 1);

    // Full write then read; partial write; zero-strobe write.
    req(0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
    req(0, 1'b0, 10'd5, 4'h0, 32'h0, 1'b0, 1'b0);
    req(0, 1'b1, 10'd5, 4'b0010, 32'h0000AA00, 1'b0, 1'b0);
    req(0, 1'b1, 10'd5, 4'h0, 32'h12345678, 1'b0, 1'b0);
    req(0, 1'b0, 10'd5, 4'h0, 32'h0, 1'b0, 1'b0);
    idle(0, 2);

    // Wait-state read with idle cycles around it.
    req(1, 1'b0, 10'd5, 4'h0, 32'h0, 1'b0, 1'b0);
    idle(1, 3);

    // Back-to-back with sel left high through the ack cycle.
    for (int d = 0; d < 2; d++) begin
      req(d, 1'b1, 10'd7, 4'hF, 32'h00001234, 1'b0, 1'b1);
      req(d, 1'b0, 10'd7, 4'h0, 32'h0, 1'b0, 1'b1);
      idle(d, 3);
    end

    // Out-of-range write and read, then addr 0 untouched.
    for (int d = 0; d < 2; d++) begin
      req(d, 1'b1, 10'd1000, 4'hF, 32'h00000055, 1'b0, 1'b0);
      req(d, 1'b0, 10'd1000, 4'h0, 32'h0, 1'b0, 1'b0);
      req(d, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 1'b0);
      idle(d, 1);
    end

    // Reset during WAIT aborts the write; next request runs normally.
    req(1, 1'b1, 10'd2, 4'hF, 32'hCAFE0002, 1'b0, 1'b0);
    idle(1, 1);
    abort_wr(10'd2);
    req(1, 1'b0, 10'd2, 4'h0, 32'h0, 1'b0, 1'b0);
    idle(1, 2);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        ra = 10'($urandom_range(0, 19));
        if (ra >= 10'd16) ra = 10'd998 + (ra - 10'd16);
        req(d, 1'($urandom), ra, 4'($urandom), $urandom, 1'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 3));
      end
      idle(d, 2);
    end

    idle(0, 10);
    chk("pending_dut0", 0, 32'(q0.size()), 32'h0);
    chk("pending_dut1", 1, 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
